// File: rtl/latch_irq_ctrl_pkg.sv
// Shared register map and per-channel state encoding for the latch interrupt collector.
package latch_irq_ctrl_pkg;

    localparam logic [1:0] REG_IE = 2'd0;
    localparam logic [1:0] REG_IP = 2'd1;
    localparam logic [1:0] REG_IS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLEAR   = 2'd2
    } ch_state_e;

    function automatic logic reg_hit(input logic we, input logic [1:0] addr,
                                     input logic [1:0] sel);
        return we && (addr == sel);
    endfunction

endpackage

// File: rtl/latch_irq_channel.sv
// One latch channel: tracks pending status and drives the latch clear until the
// synchronized latch output has actually fallen.
module latch_irq_channel
    import latch_irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic latch_sync,
    input  logic latch_edge,
    input  logic w1c,
    output logic pending,
    output logic latch_clear
);

    ch_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_CLEAR;
        else     state_q <= state_d;
    end

    // Edges seen while clearing are spurious: the latch cannot set with clear asserted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (latch_edge) state_d = ST_PENDING;
            ST_PENDING: if (w1c)        state_d = ST_CLEAR;
            ST_CLEAR:   if (!latch_sync) state_d = ST_IDLE;
            default:    state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        pending     = (state_q == ST_PENDING);
        latch_clear = (state_q == ST_CLEAR);
    end

endmodule

// File: rtl/latch_irq_ctrl.sv
// Interrupt collector for a bank of event latches: IE/IP/IS registers, per-channel
// clear handshake and a registered level interrupt.
module latch_irq_ctrl
    import latch_irq_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  latch_sync,
    input  logic [N-1:0]  latch_edge,
    output logic [N-1:0]  latch_enable,
    output logic [N-1:0]  latch_clear,
    input  logic [1:0]    reg_addr,
    input  logic          reg_we,
    input  logic [DW-1:0] reg_wdata,
    output logic [DW-1:0] reg_rdata,
    output logic          irq
);

    logic [N-1:0] ie_q, ie_d;
    logic [N-1:0] pend;
    logic [N-1:0] w1c;
    logic         irq_q, irq_d;

    assign w1c = {N{reg_hit(reg_we, reg_addr, REG_IP)}} & reg_wdata[N-1:0];

    for (genvar i = 0; i < N; i++) begin : g_ch
        latch_irq_channel u_ch (
            .clk        (clk),
            .rst        (rst),
            .latch_sync (latch_sync[i]),
            .latch_edge (latch_edge[i]),
            .w1c        (w1c[i]),
            .pending    (pend[i]),
            .latch_clear(latch_clear[i])
        );
    end

    always_comb begin
        ie_d = ie_q;
        if (reg_hit(reg_we, reg_addr, REG_IE)) ie_d = reg_wdata[N-1:0];
        irq_d = |(pend & ie_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    // Bits above N read as zero.
    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_IE:  reg_rdata[N-1:0] = ie_q;
            REG_IP:  reg_rdata[N-1:0] = pend;
            REG_IS:  reg_rdata[N-1:0] = pend & ie_q;
            default: reg_rdata = '0;
        endcase
    end

    assign latch_enable = ie_q;
    assign irq          = irq_q;

endmodule
